// File: rtl/grn_pkg.sv
// Shared definitions for the GRN node family.
//   FN_*   : encodings of the fn_sel logic-function selector
//   popcount : number of set bits in a vector of up to MAX_W bits
//              (callers zero-extend narrower vectors)
//   sat_m1   : divider reload value, d-1 clamped to 0 for d <= 1
package grn_pkg;

  localparam int MAX_W = 32;

  localparam logic [1:0] FN_OR      = 2'd0;
  localparam logic [1:0] FN_AND     = 2'd1;
  localparam logic [1:0] FN_THRESH  = 2'd2;
  localparam logic [1:0] FN_ACT_INH = 2'd3;

  function automatic logic [5:0] popcount(input logic [MAX_W-1:0] x);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < MAX_W; i++) c = c + 6'(x[i]);
    return c;
  endfunction

  function automatic logic [MAX_W-1:0] sat_m1(input logic [MAX_W-1:0] d);
    return (d <= 1) ? '0 : d - 1;
  endfunction

endpackage

// File: rtl/grn_lane.sv
// One state lane of the GRN node: update divider, logic-function
// evaluation and the s/upd/chg registers.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   reset_nos       load init_state, clear divider (next start updates)
//   init_state      value loaded on reset_nos
//   start           step strobe for this lane
//   div             update period (0 and 1 both mean every start)
//   fn_sel, thresh, inh_mask  function selection and its operands
//   x               N_IN regulator inputs
//   s, upd, chg     state, write pulse, write-and-changed pulse
import grn_pkg::*;

module grn_lane #(
  parameter int N_IN  = 2,
  parameter int DIV_W = 4,
  parameter int TH_W  = $clog2(N_IN+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reset_nos,
  input  logic             init_state,
  input  logic             start,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       fn_sel,
  input  logic [TH_W-1:0]  thresh,
  input  logic [N_IN-1:0]  inh_mask,
  input  logic [N_IN-1:0]  x,
  output logic             s,
  output logic             upd,
  output logic             chg
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] reload;
  logic             f;

  // div is read only here, so a mid-count change lands at the next reload
  assign reload = DIV_W'(sat_m1(MAX_W'(div)));

  always_comb begin
    f = 1'b0;
    unique case (fn_sel)
      FN_OR:      f = |x;
      FN_AND:     f = &x;
      // thresh wider than the popcount range naturally yields 0
      FN_THRESH:  f = (MAX_W'(popcount(MAX_W'(x))) >= MAX_W'(thresh));
      FN_ACT_INH: f = (|(x & ~inh_mask)) & ~(|(x & inh_mask));
      default:    f = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s   <= 1'b0;
      upd <= 1'b0;
      chg <= 1'b0;
      cnt <= reload;
    end else if (reset_nos) begin
      s   <= init_state;
      upd <= 1'b0;
      chg <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      if (cnt == '0) begin
        s   <= f;
        upd <= 1'b1;
        chg <= f ^ s;
        cnt <= reload;
      end else begin
        upd <= 1'b0;
        chg <= 1'b0;
        cnt <= cnt - 1'b1;
      end
    end else begin
      upd <= 1'b0;
      chg <= 1'b0;
    end
  end

endmodule

// File: rtl/grn_node_multi.sv
// Multi-lane GRN node: N_CH independent Boolean lanes, each applying a
// runtime-selected function over N_IN regulator inputs, updating on every
// div-th start strobe. Lane i uses div[i*DIV_W +: DIV_W] and
// in_bus[i*N_IN +: N_IN]; fn_sel/thresh/inh_mask are shared.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   reset_nos         load init_state into all lanes
//   init_state[N_CH]  per-lane initial value
//   start[N_CH]       per-lane step strobe
//   div, fn_sel, thresh, inh_mask, in_bus  lane configuration and inputs
//   s, upd, chg       per-lane state, update pulse, change pulse
import grn_pkg::*;

module grn_node_multi #(
  parameter int N_CH  = 2,
  parameter int N_IN  = 2,
  parameter int DIV_W = 4,
  parameter int TH_W  = $clog2(N_IN+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reset_nos,
  input  logic [N_CH-1:0]       init_state,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH*DIV_W-1:0] div,
  input  logic [1:0]            fn_sel,
  input  logic [TH_W-1:0]       thresh,
  input  logic [N_IN-1:0]       inh_mask,
  input  logic [N_CH*N_IN-1:0]  in_bus,
  output logic [N_CH-1:0]       s,
  output logic [N_CH-1:0]       upd,
  output logic [N_CH-1:0]       chg
);

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    grn_lane #(.N_IN(N_IN), .DIV_W(DIV_W), .TH_W(TH_W)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .reset_nos  (reset_nos),
      .init_state (init_state[i]),
      .start      (start[i]),
      .div        (div[i*DIV_W +: DIV_W]),
      .fn_sel     (fn_sel),
      .thresh     (thresh),
      .inh_mask   (inh_mask),
      .x          (in_bus[i*N_IN +: N_IN]),
      .s          (s[i]),
      .upd        (upd[i]),
      .chg        (chg[i])
    );
  end

endmodule
